// File: rtl/gremlin_hit_detector_pkg.sv
// Shared definitions for the gremlin hit detector: FSM encoding, play-field
// edges, VGA timing bus layout with field accessors, and BCD score helper.
package gremlin_hit_detector_pkg;

    // Detector FSM encoding
    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_TOMB    = 2'd1,
        ST_RESPAWN = 2'd2
    } grem_state_t;

    // Play-field edges used for respawn placement
    localparam int PF_LEFT_EDGE  = 5;
    localparam int PF_RIGHT_EDGE = 779;
    localparam int PF_UP_EDGE    = 105;
    localparam int PF_DOWN_EDGE  = 563;

    // VGA timing bus layout: {vblnk, hblnk, vsync, hsync, vcount[10:0], hcount[10:0]}
    localparam int VGA_BUS_SIZE   = 26;
    localparam int VGA_HCOUNT_LSB = 0;
    localparam int VGA_VCOUNT_LSB = 11;
    localparam int VGA_HSYNC_BIT  = 22;
    localparam int VGA_VSYNC_BIT  = 23;
    localparam int VGA_HBLNK_BIT  = 24;
    localparam int VGA_VBLNK_BIT  = 25;

    function automatic logic [10:0] vga_hcount(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_HCOUNT_LSB +: 11];
    endfunction

    function automatic logic [10:0] vga_vcount(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_VCOUNT_LSB +: 11];
    endfunction

    function automatic logic vga_hsync(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_HSYNC_BIT];
    endfunction

    function automatic logic vga_vsync(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_VSYNC_BIT];
    endfunction

    function automatic logic vga_hblnk(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_HBLNK_BIT];
    endfunction

    function automatic logic vga_vblnk(input logic [VGA_BUS_SIZE-1:0] bus);
        return bus[VGA_VBLNK_BIT];
    endfunction

    // Two-digit BCD increment that sticks at 99
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
        logic [7:0] r;
        if (s == 8'h99) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/gremlin_hit_detector_spawn_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with range folding
// that turns its bits into x/y offsets inside a sprite's play field.
module spawn_lfsr #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          X_RANGE = 774,
    parameter int          Y_RANGE = 458
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] o_x_off,
    output logic [8:0] o_y_off
);

    logic [15:0] r_lfsr;
    logic [15:0] r_lfsr_next;
    logic        w_feedback;
    logic [9:0]  w_x_raw;
    logic [8:0]  w_y_raw;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_x_raw    = r_lfsr[9:0];
    assign w_y_raw    = r_lfsr[15:7];

    // Shift one position per cycle, no enable: the sequence keeps advancing
    always_comb begin
        r_lfsr_next = {r_lfsr[14:0], w_feedback};
    end

    // LFSR state register, back to the nonzero seed on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= r_lfsr_next;
        end
    end

    // Fold raw bits that overshoot the field width back into range
    always_comb begin
        o_x_off = w_x_raw;
        o_y_off = w_y_raw;
        if (w_x_raw > 10'(X_RANGE)) begin
            o_x_off = w_x_raw - 10'(X_RANGE);
        end
        if (w_y_raw > 9'(Y_RANGE)) begin
            o_y_off = w_y_raw - 9'(Y_RANGE);
        end
    end

endmodule

// File: rtl/gremlin_hit_detector.sv
// Gremlin hit detector: latches car/gremlin pixel overlap during active video,
// resolves it once per frame on the vsync rising edge, shows a tombstone for
// TOMB_FRAMES frames, then requests a respawn at a pseudo-random position.
module gremlin_hit_detector
    import gremlin_hit_detector_pkg::*;
#(
    parameter int          TOMB_FRAMES = 120,
    parameter int          XPOS_INIT   = 400,
    parameter int          YPOS_INIT   = 300,
    parameter int          LEFT_EDGE   = PF_LEFT_EDGE,
    parameter int          RIGHT_EDGE  = PF_RIGHT_EDGE,
    parameter int          UP_EDGE     = PF_UP_EDGE,
    parameter int          DOWN_EDGE   = PF_DOWN_EDGE,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    input  logic                    car_color,
    input  logic                    grem_color,
    input  logic [10:0]             grem_xpos,
    input  logic [10:0]             grem_ypos,
    output logic                    grem_kill,
    output logic                    grem_spawn,
    output logic [10:0]             spawn_x,
    output logic [10:0]             spawn_y,
    output logic                    tomb_active,
    output logic [10:0]             tomb_x,
    output logic [10:0]             tomb_y,
    output logic [7:0]              score
);

    localparam int X_RANGE = RIGHT_EDGE - LEFT_EDGE;
    localparam int Y_RANGE = DOWN_EDGE - UP_EDGE;
    localparam int CNT_W   = (TOMB_FRAMES > 1) ? $clog2(TOMB_FRAMES) : 1;

    grem_state_t r_state, r_state_next;
    logic             r_kill, r_kill_next;
    logic             r_spawn, r_spawn_next;
    logic             r_tomb_active, r_tomb_active_next;
    logic [10:0]      r_tomb_x, r_tomb_x_next;
    logic [10:0]      r_tomb_y, r_tomb_y_next;
    logic [7:0]       r_score, r_score_next;
    logic [10:0]      r_spawn_x, r_spawn_x_next;
    logic [10:0]      r_spawn_y, r_spawn_y_next;
    logic             r_coll_latch, r_coll_latch_next;
    logic [CNT_W-1:0] r_tomb_cnt, r_tomb_cnt_next;
    logic             r_vsync_d, r_vsync_d_next;

    logic       w_vsync;
    logic       w_hblnk;
    logic       w_vblnk;
    logic       w_tick;
    logic       w_coll;
    logic       w_tomb_done;
    logic [9:0] w_x_off;
    logic [8:0] w_y_off;
    logic       w_unused_vga;

    assign w_vsync      = vga_vsync(vga_in);
    assign w_hblnk      = vga_hblnk(vga_in);
    assign w_vblnk      = vga_vblnk(vga_in);
    // Pixel counters and hsync are carried on the shared bus but not needed here
    assign w_unused_vga = ^{vga_hcount(vga_in), vga_vcount(vga_in), vga_hsync(vga_in)};

    assign w_tick      = w_vsync & ~r_vsync_d;
    assign w_coll      = car_color & grem_color & ~w_hblnk & ~w_vblnk;
    assign w_tomb_done = (r_tomb_cnt == CNT_W'(TOMB_FRAMES - 1));

    spawn_lfsr #(
        .SEED    (LFSR_SEED),
        .X_RANGE (X_RANGE),
        .Y_RANGE (Y_RANGE)
    ) u_spawn_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_x_off (w_x_off),
        .o_y_off (w_y_off)
    );

    // Next-state and output decode; everything holds unless a frame event moves it
    always_comb begin
        r_state_next       = r_state;
        r_kill_next        = 1'b0;
        r_spawn_next       = 1'b0;
        r_tomb_active_next = r_tomb_active;
        r_tomb_x_next      = r_tomb_x;
        r_tomb_y_next      = r_tomb_y;
        r_score_next       = r_score;
        r_spawn_x_next     = r_spawn_x;
        r_spawn_y_next     = r_spawn_y;
        r_tomb_cnt_next    = r_tomb_cnt;
        r_vsync_d_next     = w_vsync;

        // Latch clears at every frame boundary; overlap is ignored while the
        // tombstone is up, but one landing in the respawn cycle carries forward
        if (w_tick) begin
            r_coll_latch_next = 1'b0;
        end else if ((r_state != ST_TOMB) && w_coll) begin
            r_coll_latch_next = 1'b1;
        end else begin
            r_coll_latch_next = r_coll_latch;
        end

        case (r_state)
            ST_ALIVE: begin
                // Same-cycle overlap is folded in so a hit on the tick pixel counts
                if (w_tick && (r_coll_latch || w_coll)) begin
                    r_state_next       = ST_TOMB;
                    r_kill_next        = 1'b1;
                    r_tomb_active_next = 1'b1;
                    r_tomb_x_next      = grem_xpos;
                    r_tomb_y_next      = grem_ypos;
                    r_tomb_cnt_next    = '0;
                    r_score_next       = bcd_inc_sat(r_score);
                end
            end
            ST_TOMB: begin
                if (w_tick) begin
                    if (w_tomb_done) begin
                        r_state_next = ST_RESPAWN;
                    end else begin
                        r_tomb_cnt_next = r_tomb_cnt + CNT_W'(1);
                    end
                end
            end
            ST_RESPAWN: begin
                r_state_next       = ST_ALIVE;
                r_spawn_next       = 1'b1;
                r_tomb_active_next = 1'b0;
                r_spawn_x_next     = 11'(LEFT_EDGE) + {1'b0, w_x_off};
                r_spawn_y_next     = 11'(UP_EDGE) + {2'b00, w_y_off};
            end
            default: begin
                r_state_next = ST_ALIVE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_ALIVE;
            r_kill        <= 1'b0;
            r_spawn       <= 1'b0;
            r_tomb_active <= 1'b0;
            r_tomb_x      <= '0;
            r_tomb_y      <= '0;
            r_score       <= 8'h00;
            r_spawn_x     <= 11'(XPOS_INIT);
            r_spawn_y     <= 11'(YPOS_INIT);
            r_coll_latch  <= 1'b0;
            r_tomb_cnt    <= '0;
            r_vsync_d     <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            r_kill        <= r_kill_next;
            r_spawn       <= r_spawn_next;
            r_tomb_active <= r_tomb_active_next;
            r_tomb_x      <= r_tomb_x_next;
            r_tomb_y      <= r_tomb_y_next;
            r_score       <= r_score_next;
            r_spawn_x     <= r_spawn_x_next;
            r_spawn_y     <= r_spawn_y_next;
            r_coll_latch  <= r_coll_latch_next;
            r_tomb_cnt    <= r_tomb_cnt_next;
            r_vsync_d     <= r_vsync_d_next;
        end
    end

    assign grem_kill   = r_kill;
    assign grem_spawn  = r_spawn;
    assign spawn_x     = r_spawn_x;
    assign spawn_y     = r_spawn_y;
    assign tomb_active = r_tomb_active;
    assign tomb_x      = r_tomb_x;
    assign tomb_y      = r_tomb_y;
    assign score       = r_score;

endmodule

// File: doc/gremlin_hit_detector.md
Name: gremlin_hit_detector

Overview:
- Consumer end of the gremlin sprite's position and pixel outputs.
- Detects per-pixel car/gremlin overlap during active video and resolves hits once per frame.
- On a hit it drives a tombstone at the kill position, bumps the BCD kill score, and after a tomb period issues a respawn request with a pseudo-random in-field position.
- Sits beside the gremlin and car renderers in the per-frame VGA pipeline.

Parameters:
- TOMB_FRAMES, 120: frames the tombstone stays shown before respawn (must be >=1).
- XPOS_INIT, 400: spawn_x value after reset.
- YPOS_INIT, 300: spawn_y value after reset.
- LEFT_EDGE, 5: minimum spawn x.
- RIGHT_EDGE, 779: maximum spawn x.
- UP_EDGE, 105: minimum spawn y.
- DOWN_EDGE, 563: maximum spawn y.
- LFSR_SEED, 16'hACE1: LFSR value after reset (nonzero).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- vga_in  in  VGA_BUS_SIZE  shared VGA timing bus (hcount, vcount, hsync, vsync, hblnk, vblnk)
- car_color  in  1  car sprite pixel opaque at current hcount/vcount
- grem_color  in  1  gremlin sprite pixel opaque at current hcount/vcount
- grem_xpos  in  11  gremlin top-left x
- grem_ypos  in  11  gremlin top-left y
- grem_kill  out  1  one-cycle pulse: gremlin hit
- grem_spawn  out  1  one-cycle pulse: load spawn_x/spawn_y and resume
- spawn_x  out  11  respawn x, valid while grem_spawn=1 and held after
- spawn_y  out  11  respawn y
- tomb_active  out  1  tombstone should be drawn
- tomb_x  out  11  tombstone x
- tomb_y  out  11  tombstone y
- score  out  8  two BCD digits, [7:4] tens, [3:0] units

Behaviour:
- All state updates on posedge clk. Reset applies when reset==0 at a clock edge.
- Reset values: state ALIVE; grem_kill=0; grem_spawn=0; tomb_active=0; tomb_x=tomb_y=0; score=8'h00; spawn_x=XPOS_INIT; spawn_y=YPOS_INIT; coll_latch=0; tomb_cnt=0; vsync_d=0; lfsr=LFSR_SEED.
- Frame tick: tick = vsync_in & ~vsync_d. vsync_d is a register.
- Collision: coll = car_color & grem_color & ~hblnk_in & ~vblnk_in. In ALIVE, coll sets coll_latch. In TOMB, coll is ignored.
- coll_latch clears on every tick, in all states.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle including during TOMB.

FSM:
- ALIVE:
  - On tick with (coll_latch | coll): go to TOMB.
  - Same cycle: grem_kill=1 for exactly one cycle; tomb_x/tomb_y capture grem_xpos/grem_ypos; tomb_active=1; tomb_cnt=0; score increments in BCD.
  - On tick without a hit: stay in ALIVE.
- TOMB:
  - On each tick: if tomb_cnt==TOMB_FRAMES-1, go to RESPAWN; else tomb_cnt+1.
- RESPAWN (one cycle):
  - grem_spawn=1; tomb_active=0.
  - spawn_x = LEFT_EDGE + xo, where xo = lfsr[9:0], minus (RIGHT_EDGE-LEFT_EDGE) if xo exceeds it.
  - spawn_y = UP_EDGE + yo, with the same rule using lfsr[15:7] and (DOWN_EDGE-UP_EDGE).
  - Next state ALIVE.
- Latency:
  - grem_kill asserts in the tick cycle, the same edge that registers vsync_d.
  - grem_spawn asserts TOMB_FRAMES ticks after kill, plus 1 cycle.

Score:
- Units 9 rolls to 0 with a tens carry.
- Saturates at 8'h99: further hits still kill the gremlin but leave score unchanged.

Boundaries:
- A collision sampled in the same cycle as the tick counts toward that frame.
- A collision arriving in the RESPAWN cycle is counted in the next frame.
- Reset low mid-TOMB: immediate return to reset values, no spawn pulse.

Decomposition:
- Shared package/header: FSM state encoding (ALIVE=2'd0, TOMB=2'd1, RESPAWN=2'd2), play-field edge constants, VGA bus split macros.
- One sub-module is natural: spawn_lfsr (LFSR plus range folding producing x/y offsets), reusable for other sprites.

Test Plan:
- car and gremlin pixels overlap at (420,310) in active video, grem pos (412,300), score 00 -> on next vsync rise: grem_kill 1 cycle, tomb_active=1, tomb=(412,300), score=8'h01.
- Overlap only while hblnk=1 or vblnk=1 -> no grem_kill over 3 frames, score unchanged.
- TOMB_FRAMES=4, kill then run 6 frames with continuous overlap -> score increments once; grem_spawn pulses exactly once, 4 ticks after kill plus 1 cycle; tomb_active drops on that cycle; spawn_x in [5,779] and spawn_y in [105,563].
- Preload score 8'h09, then hit -> 8'h10. Preload 8'h99, then hit -> grem_kill asserts, score stays 8'h99.
- reset low for 1 cycle at tick 2 of TOMB -> next cycle: state ALIVE, tomb_active=0, score=00, spawn=(400,300), no grem_spawn pulse.
- 200 forced kill/respawn cycles -> every spawn_x/spawn_y within edges; LFSR never reaches 0.
